force_reg_bank: RTL

- Parametrised bank of CHANNELS clocked registers, each WIDTH bits wide, with per-bit force/release override driven by a command port.
- Models SystemVerilog variable force/release semantics in synthesisable RTL:
  - A forced bit shows the forced value.
  - A released bit keeps the forced value until the next enabled write.
- Sits beside the simulator-interface test infrastructure as the hardware counterpart to VPI force/release checks, and is reused as an override block for debug.

---
 rtl/force_reg_pkg.sv | 20 ++
 rtl/force_reg_chan.sv | 59 +++++
 rtl/force_reg_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/force_reg_pkg.sv
// Shared types for the force/release register bank: command op-codes and
// controller states.
package force_reg_pkg;

  localparam int unsigned OpW = 2;

  typedef enum logic [OpW-1:0] {
    OpNop        = 2'd0,
    OpForce      = 2'd1,
    OpRelease    = 2'd2,
    OpReleaseAll = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

endpackage

// File: rtl/force_reg_chan.sv
// One channel of the force bank: the written register, per-bit force flags and
// the per-bit force values. Output q is a pure function of those three registers.
module force_reg_chan #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             force_strobe,
  input  logic             release_strobe,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] forced
);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] forced_q, forced_d;
  logic [WIDTH-1:0] fval_q, fval_d;
  logic [WIDTH-1:0] rel_bits;

  always_comb begin
    reg_d    = reg_q;
    forced_d = forced_q;
    fval_d   = fval_q;
    rel_bits = '0;
    if (release_strobe) begin
      // Released bits keep showing their forced value until the next write.
      rel_bits = mask & forced_q;
      reg_d    = (reg_q & ~rel_bits) | (fval_q & rel_bits);
      forced_d = forced_q & ~mask;
    end
    if (force_strobe) begin
      forced_d = forced_q | mask;
      fval_d   = (fval_q & ~mask) | (value & mask);
    end
    if (en) begin
      reg_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q    <= RESET_VALUE;
      forced_q <= '0;
      fval_q   <= '0;
    end else begin
      reg_q    <= reg_d;
      forced_q <= forced_d;
      fval_q   <= fval_d;
    end
  end

  assign q      = (forced_q & fval_q) | (~forced_q & reg_q);
  assign forced = forced_q;

endmodule

// File: rtl/force_reg_bank.sv
// Bank of CHANNELS registers with per-bit force/release overrides; holds the
// command decode, the controller FSM and the RELEASE_ALL sweep counter.
module force_reg_bank
  import force_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      CHANNELS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     ChanW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OpW-1:0]            cmd_op,
  input  logic [ChanW-1:0]          cmd_chan,
  input  logic [WIDTH-1:0]          cmd_mask,
  input  logic [WIDTH-1:0]          cmd_value,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] forced,
  output logic                      any_forced,
  output logic                      cmd_done
);

  state_e              state_q, state_d;
  logic [ChanW-1:0]    idx_q, idx_d;
  cmd_op_e             op;
  logic                accept;
  logic [CHANNELS-1:0] cmd_sel, idx_sel;
  logic [CHANNELS-1:0] force_vec, release_vec;
  logic [WIDTH-1:0]    mask_bus;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == StIdle);
  assign cmd_done  = (state_q == StDone);
  assign accept    = cmd_valid && cmd_ready;

  // An out-of-range cmd_chan selects no channel, so the command degrades to a NOP.
  always_comb begin
    cmd_sel = '0;
    idx_sel = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      cmd_sel[c] = (cmd_chan == ChanW'(c));
      idx_sel[c] = (idx_q == ChanW'(c));
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    force_vec   = '0;
    release_vec = '0;
    mask_bus    = cmd_mask;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpForce: begin
              force_vec = cmd_sel;
              state_d   = StDone;
            end
            OpRelease: begin
              release_vec = cmd_sel;
              state_d     = StDone;
            end
            OpReleaseAll: begin
              idx_d   = '0;
              state_d = StSweep;
            end
            default: state_d = StDone;
          endcase
        end
      end
      StSweep: begin
        mask_bus    = '1;
        release_vec = idx_sel;
        idx_d       = idx_q + ChanW'(1);
        if (idx_q == ChanW'(CHANNELS - 1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    force_reg_chan #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .en             (en[i]),
      .d              (d[i*WIDTH +: WIDTH]),
      .force_strobe   (force_vec[i]),
      .release_strobe (release_vec[i]),
      .mask           (mask_bus),
      .value          (cmd_value),
      .q              (q[i*WIDTH +: WIDTH]),
      .forced         (forced[i*WIDTH +: WIDTH])
    );
  end

  assign any_forced = |forced;

endmodule
